// File: rtl/keccak_pkg.sv
// Shared Keccak constants: lane count, rho rotation offsets and the FSM
// state type used by the serial rho engine.
package keccak_pkg;

    localparam int NUM_LANES = 25;

    localparam int RHO_OFF [0:24] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } rho_state_e;

    // Rotation amount actually applied to lane n for lane width w (w is a power of two).
    function automatic int eff_off(input int n, input int w);
        return RHO_OFF[n] % w;
    endfunction

    function automatic int off_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/keccak_lane_rot.sv
// Combinational barrel rotator for one Keccak lane: rotate left by offset,
// or right by offset when inv is set.
module keccak_lane_rot #(
    parameter int LANE_W = 64,
    parameter int OFF_W  = 6
) (
    input  logic [LANE_W-1:0] lane_in,
    input  logic [OFF_W-1:0]  offset,
    input  logic              inv,
    output logic [LANE_W-1:0] lane_out
);

    // Complementary shift; equals LANE_W for offset 0, which shifts everything out.
    logic [OFF_W:0]      comp;
    logic [LANE_W-1:0]   rot_l;
    logic [LANE_W-1:0]   rot_r;

    assign comp     = (OFF_W+1)'(LANE_W) - {1'b0, offset};
    assign rot_l    = (lane_in << offset) | (lane_in >> comp);
    assign rot_r    = (lane_in >> offset) | (lane_in << comp);
    assign lane_out = inv ? rot_r : rot_l;

endmodule

// File: rtl/keccak_rho_serial.sv
// Sequential Keccak rho step: rotates LANES_PER_CYC lanes of a captured state
// per cycle, forward or inverse, behind valid/ready handshakes.
module keccak_rho_serial
    import keccak_pkg::*;
#(
    parameter int LANE_W        = 64,
    parameter int LANES_PER_CYC = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_inv,
    input  logic [NUM_LANES*LANE_W-1:0]   state_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*LANE_W-1:0]   state_out
);

    localparam int NUM_GRP = NUM_LANES / LANES_PER_CYC;
    localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int OFF_W   = off_width(LANE_W);
    localparam int STATE_W = NUM_LANES * LANE_W;

    rho_state_e           state, state_nx;
    logic [GRP_W-1:0]     grp, grp_nx;
    logic                 inv_q, inv_nx;
    logic [STATE_W-1:0]   work, work_nx;

    logic [LANE_W-1:0]    rot_in  [LANES_PER_CYC];
    logic [LANE_W-1:0]    rot_out [LANES_PER_CYC];
    logic [OFF_W-1:0]     rot_off [LANES_PER_CYC];

    // NOTE: the work register is reset on purpose so an aborted operation
    // leaves state_out at zero rather than exposing a half-rotated state.
    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grp   <= '0;
            inv_q <= 1'b0;
            work  <= '0;
        end else begin
            state <= state_nx;
            grp   <= grp_nx;
            inv_q <= inv_nx;
            work  <= work_nx;
        end
    end

    // Select the lanes of the current group and their compile-time offsets.
    always_comb begin
        for (int i = 0; i < LANES_PER_CYC; i++) begin
            rot_in[i]  = work[(int'(grp) * LANES_PER_CYC + i) * LANE_W +: LANE_W];
            rot_off[i] = '0;
            for (int g = 0; g < NUM_GRP; g++) begin
                if (grp == GRP_W'(g))
                    rot_off[i] = OFF_W'(eff_off(g * LANES_PER_CYC + i, LANE_W));
            end
        end
    end

    for (genvar i = 0; i < LANES_PER_CYC; i++) begin : g_rot
        keccak_lane_rot #(
            .LANE_W (LANE_W),
            .OFF_W  (OFF_W)
        ) u_rot (
            .lane_in  (rot_in[i]),
            .offset   (rot_off[i]),
            .inv      (inv_q),
            .lane_out (rot_out[i])
        );
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nx  = state;
        grp_nx    = grp;
        inv_nx    = inv_q;
        work_nx   = work;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    work_nx  = state_in;
                    inv_nx   = in_inv;
                    grp_nx   = '0;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < LANES_PER_CYC; i++)
                    work_nx[(int'(grp) * LANES_PER_CYC + i) * LANE_W +: LANE_W] = rot_out[i];
                if (grp == GRP_W'(NUM_GRP - 1)) begin
                    grp_nx   = '0;
                    state_nx = DONE;
                end else begin
                    grp_nx = grp + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign state_out = work;

endmodule

// File: tb/tb_keccak_rho_serial.sv
// Self-checking bench for keccak_rho_serial: four parameterisations run
// directed vectors, then random forward/inverse round trips in parallel.
module tb_keccak_rho_serial;

    localparam int WS [4] = '{64, 64, 8, 1};
    localparam int NS [4] = '{5, 1, 25, 5};
    localparam int PAIRS  = 200;
    localparam int RHO [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43,
                                25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    logic clk = 1'b0;
    logic rst;
    logic iv [4];
    logic ii [4];
    logic ordy [4];
    logic [1599:0] si [4];

    wire ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3;
    wire [1599:0] so0, so1;
    wire [199:0]  so2;
    wire [24:0]   so3;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    keccak_rho_serial #(.LANE_W(64), .LANES_PER_CYC(5)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_inv(ii[0]),
        .state_in(si[0]), .out_valid(ov0), .out_ready(ordy[0]), .state_out(so0));
    keccak_rho_serial #(.LANE_W(64), .LANES_PER_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_inv(ii[1]),
        .state_in(si[1]), .out_valid(ov1), .out_ready(ordy[1]), .state_out(so1));
    keccak_rho_serial #(.LANE_W(8), .LANES_PER_CYC(25)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .in_inv(ii[2]),
        .state_in(si[2][199:0]), .out_valid(ov2), .out_ready(ordy[2]), .state_out(so2));
    keccak_rho_serial #(.LANE_W(1), .LANES_PER_CYC(5)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir3), .in_inv(ii[3]),
        .state_in(si[3][24:0]), .out_valid(ov3), .out_ready(ordy[3]), .state_out(so3));

    function automatic logic [1599:0] get_out(input int k);
        case (k)
            0:       return so0;
            1:       return so1;
            2:       return 1600'(so2);
            default: return 1600'(so3);
        endcase
    endfunction

    function automatic logic get_rdy(input int k);
        case (k)
            0:       return ir0;
            1:       return ir1;
            2:       return ir2;
            default: return ir3;
        endcase
    endfunction

    function automatic logic get_vld(input int k);
        case (k)
            0:       return ov0;
            1:       return ov1;
            2:       return ov2;
            default: return ov3;
        endcase
    endfunction

    function automatic logic [1599:0] state_mask(input int w);
        logic [1599:0] m;
        m = '1;
        if (w < 64) m = (1600'(1) << (25 * w)) - 1600'(1);
        return m;
    endfunction

    function automatic logic [1599:0] rand_state(input int w);
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[i*32 +: 32] = $urandom;
        return s & state_mask(w);
    endfunction

    // Bit-level definition: output bit k of lane n comes from input bit (k -/+ e) mod w.
    function automatic logic [1599:0] rho_model(input logic [1599:0] s, input int w, input logic inv);
        logic [1599:0] r;
        int e, src;
        r = '0;
        for (int n = 0; n < 25; n++) begin
            e = RHO[n] % w;
            for (int k = 0; k < w; k++) begin
                src = inv ? (k + e) % w : (k - e + w) % w;
                r[n*w + k] = s[n*w + src];
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        int idx;
        n_checks++;
        if (act !== exp) begin
            n_err++;
            idx = 0;
            for (int c = 24; c >= 0; c--)
                if (act[c*64 +: 64] !== exp[c*64 +: 64]) idx = c;
            $display("FAIL %s: word %0d got %h expected %h", name, idx,
                     act[idx*64 +: 64], exp[idx*64 +: 64]);
        end
    endtask

    // One transaction on instance k, with bp cycles of backpressure during which
    // in_valid is pulsed randomly and outputs must hold steady.
    task automatic run_txn(input int k, input logic [1599:0] st, input logic inv,
                           input int bp, output logic [1599:0] res);
        int t;
        int g;
        g = 25 / NS[k];
        ordy[k] = 1'b0;
        t = 0;
        while (!get_rdy(k) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("in_ready_wait[%0d]", k), 1600'(get_rdy(k)), 1600'(1));
        si[k] = st;
        ii[k] = inv;
        iv[k] = 1'b1;
        @(negedge clk);
        iv[k] = 1'b0;
        ii[k] = ~inv;
        si[k] = rand_state(WS[k]);
        t = 1;
        while (!get_vld(k) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("latency[%0d]", k), 1600'(t), 1600'(g + 1));
        check($sformatf("in_ready_done[%0d]", k), 1600'(get_rdy(k)), 1600'(0));
        res = get_out(k);
        check($sformatf("data[%0d]", k), res, rho_model(st, WS[k], inv));
        for (int i = 0; i < bp; i++) begin
            iv[k] = 1'($urandom);
            si[k] = rand_state(WS[k]);
            @(negedge clk);
            check($sformatf("bp_valid[%0d]", k), 1600'(get_vld(k)), 1600'(1));
            check($sformatf("bp_ready[%0d]", k), 1600'(get_rdy(k)), 1600'(0));
            check($sformatf("bp_data[%0d]", k), get_out(k), res);
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
        check($sformatf("consumed_valid[%0d]", k), 1600'(get_vld(k)), 1600'(0));
        check($sformatf("consumed_ready[%0d]", k), 1600'(get_rdy(k)), 1600'(1));
    endtask

    task automatic rand_run(input int k);
        logic [1599:0] st, r1, r2;
        logic inv;
        for (int i = 0; i < PAIRS; i++) begin
            st  = rand_state(WS[k]);
            inv = 1'($urandom);
            run_txn(k, st, inv, $urandom_range(0, 3), r1);
            run_txn(k, r1, ~inv, $urandom_range(0, 3), r2);
            check($sformatf("roundtrip[%0d]", k), r2, st);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1599:0] st, exp, res;
        bit seen;

        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b0; ii[k] = 1'b0; ordy[k] = 1'b0; si[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_ready[%0d]", k), 1600'(get_rdy(k)), 1600'(0));
            check($sformatf("rst_valid[%0d]", k), 1600'(get_vld(k)), 1600'(0));
            check($sformatf("rst_data[%0d]", k), get_out(k), '0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++)
            check($sformatf("post_rst_ready[%0d]", k), 1600'(get_rdy(k)), 1600'(1));
        @(negedge clk);

        // Pin the model itself with hand-computed values.
        st = '0; st[64 +: 64] = 64'h1;
        exp = '0; exp[64 +: 64] = 64'h2;
        check("model_fwd_lane1", rho_model(st, 64, 1'b0), exp);
        st = '0; st[128 +: 64] = 64'h1;
        exp = '0; exp[128 +: 64] = 64'h4;
        check("model_inv_lane2", rho_model(st, 64, 1'b1), exp);

        // W=64 N=5 forward, lane 1 rotates by 1.
        st = '0; st[64 +: 64] = 64'h1;
        exp = '0; exp[64 +: 64] = 64'h2;
        run_txn(0, st, 1'b0, 0, res);
        check("dir_w64n5", res, exp);

        // W=64 N=1 inverse, lane 2 rotates right by 62.
        st = '0; st[128 +: 64] = 64'h1;
        exp = '0; exp[128 +: 64] = 64'h4;
        run_txn(1, st, 1'b1, 0, res);
        check("dir_w64n1_inv", res, exp);

        // W=8 N=25 forward: offsets 62 mod 8 = 6 and 36 mod 8 = 4.
        st = '0; st[16 +: 8] = 8'h01; st[40 +: 8] = 8'h80;
        exp = '0; exp[16 +: 8] = 8'h40; exp[40 +: 8] = 8'h08;
        run_txn(2, st, 1'b0, 0, res);
        check("dir_w8n25", res, exp);

        // Long backpressure with in_valid pulses.
        st = '0; st[0 +: 64] = 64'hDEAD_BEEF_0123_4567; st[24*64 +: 64] = 64'h8000_0000_0000_0001;
        exp = '0; exp[0 +: 64] = 64'hDEAD_BEEF_0123_4567; exp[24*64 +: 64] = 64'h0000_0000_0000_6000;
        run_txn(0, st, 1'b0, 10, res);
        check("dir_backpressure", res, exp);

        // Reset in the second BUSY cycle aborts the operation.
        st = rand_state(64);
        si[0] = st; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rst_ready", 1600'(get_rdy(0)), 1600'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_valid", 1600'(get_vld(0)), 1600'(0));
        check("abort_data", get_out(0), '0);
        check("abort_ready", 1600'(get_rdy(0)), 1600'(1));
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (get_vld(0)) seen = 1'b1;
        end
        check("abort_no_result", 1600'(seen), 1600'(0));

        // Reset together with in_valid: the state must not be accepted.
        si[0] = rand_state(64); iv[0] = 1'b1; rst = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0; rst = 1'b0;
        #1;
        check("rstvalid_ready", 1600'(get_rdy(0)), 1600'(1));
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (get_vld(0)) seen = 1'b1;
        end
        check("rstvalid_no_accept", 1600'(seen), 1600'(0));
        check("rstvalid_data", get_out(0), '0);

        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
            rand_run(3);
        join

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
